// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that shares one APB master port between NB_REQ requesters.
// Sequences SETUP/ACCESS, tolerates wait states, and can force-complete stalled transfers.
module apb_rr_arbiter #(
    parameter int unsigned NB_REQ         = 4,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT        = 256
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NB_REQ-1:0]                  req_valid_i,
    input  logic [NB_REQ-1:0]                  req_write_i,
    input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   req_wdata_i,
    output logic [NB_REQ-1:0]                  rsp_valid_o,
    output logic [APB_DATA_WIDTH-1:0]          rsp_rdata_o,
    output logic                               rsp_err_o,
    output logic                               busy_o,
    output logic                               psel_o,
    output logic                               penable_o,
    output logic                               pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]          paddr_o,
    output logic [APB_DATA_WIDTH-1:0]          pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]          prdata_i,
    input  logic                               pready_i,
    input  logic                               pslverr_i
);

    localparam int unsigned IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int unsigned WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0]  WD_LAST   = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NB_REQ - 1);
    localparam logic             WD_ENABLE = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [WD_W-1:0]             wd_q, wd_d;
    logic                        psel_q, psel_d;
    logic                        penable_q, penable_d;
    logic                        pwrite_q, pwrite_d;
    logic [APB_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [NB_REQ-1:0]           rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                        rsp_err_q, rsp_err_d;

    logic [NB_REQ-1:0]           elig;
    logic                        gnt_found;
    logic [IDX_W-1:0]            gnt_idx;
    int unsigned                 cand;
    logic                        timeout;
    logic                        done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            wd_q        <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            idx_q       <= idx_d;
            wd_q        <= wd_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // The requester being acknowledged this cycle still shows req_valid high; masking it avoids a re-issue.
    always_comb begin
        elig      = req_valid_i & ~rsp_valid_q;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= NB_REQ) begin
                cand = cand - NB_REQ;
            end
            if (!gnt_found && elig[cand[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end

        timeout = WD_ENABLE && !pready_i && (wd_q == WD_LAST);
        done    = (state_q == ACCESS) && (pready_i || timeout);

        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_found) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        idx_d       = idx_q;
        wd_d        = '0;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        psel_d      = (state_d != IDLE);
        penable_d   = (state_d == ACCESS);

        // The APB address/data registers double as the latched request for the whole transfer.
        if (state_q == IDLE && gnt_found) begin
            idx_d    = gnt_idx;
            rr_ptr_d = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
            pwrite_d = req_write_i[gnt_idx];
            paddr_d  = req_addr_i[32'(gnt_idx)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            pwdata_d = req_wdata_i[32'(gnt_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        end

        if (state_q == ACCESS) begin
            if (!done) begin
                wd_d = wd_q + 1'b1;
            end else begin
                rsp_valid_d[idx_q] = 1'b1;
                if (pready_i) begin
                    rsp_rdata_d = pwrite_q ? '0 : prdata_i;
                    rsp_err_d   = pslverr_i;
                end else begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
